// File: rtl/wb_openram_port0_arbiter_if.sv
// Bus bundle for the OpenRAM port-0 arbiter: two Wishbone
// slave ports, the write-protect strap and the RAM port-0 pins.
interface wb_openram_port0_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 32
);
  logic          wbsa_stb_i;
  logic          wbsa_cyc_i;
  logic          wbsa_we_i;
  logic [DW/8-1:0] wbsa_sel_i;
  logic [DW-1:0] wbsa_dat_i;
  logic [31:0]   wbsa_adr_i;
  logic          wbsa_ack_o;
  logic [DW-1:0] wbsa_dat_o;

  logic          wbsb_stb_i;
  logic          wbsb_cyc_i;
  logic          wbsb_we_i;
  logic [DW/8-1:0] wbsb_sel_i;
  logic [DW-1:0] wbsb_dat_i;
  logic [31:0]   wbsb_adr_i;
  logic          wbsb_ack_o;
  logic [DW-1:0] wbsb_dat_o;

  logic          writable_b;
  logic          grant_b_o;

  logic          ram_clk0;
  logic          ram_csb0;
  logic          ram_web0;
  logic [DW/8-1:0] ram_wmask0;
  logic [AW-1:0] ram_addr0;
  logic [DW-1:0] ram_din0;
  logic [DW-1:0] ram_dout0;

  modport slave (
    input  wbsa_stb_i, wbsa_cyc_i, wbsa_we_i,
    input  wbsa_sel_i, wbsa_dat_i, wbsa_adr_i,
    output wbsa_ack_o, wbsa_dat_o,
    input  wbsb_stb_i, wbsb_cyc_i, wbsb_we_i,
    input  wbsb_sel_i, wbsb_dat_i, wbsb_adr_i,
    output wbsb_ack_o, wbsb_dat_o,
    input  writable_b,
    output grant_b_o,
    output ram_clk0, ram_csb0, ram_web0,
    output ram_wmask0, ram_addr0, ram_din0,
    input  ram_dout0
  );

  modport master (
    output wbsa_stb_i, wbsa_cyc_i, wbsa_we_i,
    output wbsa_sel_i, wbsa_dat_i, wbsa_adr_i,
    input  wbsa_ack_o, wbsa_dat_o,
    output wbsb_stb_i, wbsb_cyc_i, wbsb_we_i,
    output wbsb_sel_i, wbsb_dat_i, wbsb_adr_i,
    input  wbsb_ack_o, wbsb_dat_o,
    output writable_b,
    input  grant_b_o,
    input  ram_clk0, ram_csb0, ram_web0,
    input  ram_wmask0, ram_addr0, ram_din0,
    output ram_dout0
  );
endinterface

// File: rtl/wb_openram_port0_arbiter.sv
// Round-robin arbiter sharing OpenRAM port 0 between two
// Wishbone slave ports, one transaction in flight.
module wb_openram_port0_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic wb_clk_i,
  input  logic wb_rst_i,
  wb_openram_port0_arbiter_if.slave bus
);
  localparam int MW = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    S_IDLE, S_ISSUE, S_RESP, S_ACK
  } state_t;

  state_t r_state;
  logic r_last_b;
  logic r_grant_b;
  logic r_wr;
  logic r_csb;
  logic r_web;
  logic r_ack_a;
  logic r_ack_b;
  logic [MW-1:0]         r_wmask;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_din;
  logic [DATA_WIDTH-1:0] r_dat_a;
  logic [DATA_WIDTH-1:0] r_dat_b;

  logic w_req_a;
  logic w_req_b;
  logic w_any;
  logic w_pick_b;
  logic w_we;
  logic w_protect;
  logic [31:0]           w_adr;
  logic [DATA_WIDTH-1:0] w_dat;
  logic [MW-1:0]         w_sel;
  logic                  w_unused;

  assign w_req_a  = bus.wbsa_stb_i & bus.wbsa_cyc_i;
  assign w_req_b  = bus.wbsb_stb_i & bus.wbsb_cyc_i;
  assign w_any    = w_req_a | w_req_b;
  // B wins when alone, or on a tie when A was served last
  assign w_pick_b = w_req_b & (~w_req_a | ~r_last_b);
  assign w_we  = w_pick_b ? bus.wbsb_we_i  : bus.wbsa_we_i;
  assign w_adr = w_pick_b ? bus.wbsb_adr_i : bus.wbsa_adr_i;
  assign w_dat = w_pick_b ? bus.wbsb_dat_i : bus.wbsa_dat_i;
  assign w_sel = w_pick_b ? bus.wbsb_sel_i : bus.wbsa_sel_i;
  assign w_protect = w_pick_b & bus.wbsb_we_i & ~bus.writable_b;
  assign w_unused  = ^{w_adr[31:ADDR_WIDTH+2], w_adr[1:0]};

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state   <= S_IDLE;
      r_last_b  <= 1'b1;
      r_grant_b <= 1'b0;
      r_wr      <= 1'b0;
      r_csb     <= 1'b1;
      r_web     <= 1'b1;
      r_ack_a   <= 1'b0;
      r_ack_b   <= 1'b0;
      r_wmask   <= '0;
      r_addr    <= '0;
      r_din     <= '0;
      r_dat_a   <= '0;
      r_dat_b   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_addr    <= w_adr[ADDR_WIDTH+1:2];
            r_din     <= w_dat;
            r_wmask   <= w_sel;
            r_web     <= ~w_we;
            r_wr      <= w_we;
            r_csb     <= w_protect;
            r_last_b  <= w_pick_b;
            r_grant_b <= w_pick_b;
            r_state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_csb   <= 1'b1;
          r_web   <= 1'b1;
          r_state <= S_RESP;
        end
        S_RESP: begin
          if (r_grant_b) begin
            r_ack_b <= 1'b1;
            if (!r_wr) r_dat_b <= bus.ram_dout0;
          end else begin
            r_ack_a <= 1'b1;
            if (!r_wr) r_dat_a <= bus.ram_dout0;
          end
          r_state <= S_ACK;
        end
        S_ACK: begin
          r_ack_a <= 1'b0;
          r_ack_b <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.ram_clk0   = wb_clk_i;
  assign bus.ram_csb0   = r_csb;
  assign bus.ram_web0   = r_web;
  assign bus.ram_wmask0 = r_wmask;
  assign bus.ram_addr0  = r_addr;
  assign bus.ram_din0   = r_din;
  assign bus.wbsa_ack_o = r_ack_a;
  assign bus.wbsb_ack_o = r_ack_b;
  assign bus.wbsa_dat_o = r_dat_a;
  assign bus.wbsb_dat_o = r_dat_b;
  assign bus.grant_b_o  = r_grant_b;
endmodule

// File: tb/tb_wb_openram_port0_arbiter.sv
// Directed bench for the OpenRAM port-0 arbiter with a
// behavioural 32x256 byte-masked RAM model.
module tb_wb_openram_port0_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  wb_openram_port0_arbiter_if #(.AW(8), .DW(32)) bus();

  wb_openram_port0_arbiter #(
    .ADDR_WIDTH(8),
    .DATA_WIDTH(32)
  ) dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .bus(bus.slave)
  );

  logic [31:0] mem [256];

  always @(posedge bus.ram_clk0) begin
    if (!bus.ram_csb0) begin
      if (!bus.ram_web0) begin
        for (int k = 0; k < 4; k++)
          if (bus.ram_wmask0[k])
            mem[bus.ram_addr0][8*k +: 8] <= bus.ram_din0[8*k +: 8];
      end else begin
        bus.ram_dout0 <= mem[bus.ram_addr0];
      end
    end
  end

  typedef struct {
    bit          pb;
    bit          we;
    bit          wrb;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    bit          exp_csb;
    logic [7:0]  exp_addr;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t v [10];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit pb, input bit on, input bit we,
                       input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel);
    if (pb) begin
      bus.wbsb_stb_i = on; bus.wbsb_cyc_i = on;
      bus.wbsb_we_i = we; bus.wbsb_adr_i = adr;
      bus.wbsb_dat_i = dat; bus.wbsb_sel_i = sel;
    end else begin
      bus.wbsa_stb_i = on; bus.wbsa_cyc_i = on;
      bus.wbsa_we_i = we; bus.wbsa_adr_i = adr;
      bus.wbsa_dat_i = dat; bus.wbsa_sel_i = sel;
    end
  endtask

  task automatic txn(input bit pb, input bit we,
                     input logic [31:0] adr, input logic [31:0] dat,
                     input logic [3:0] sel,
                     output logic [31:0] rd, output int lat,
                     output logic csb, output logic [7:0] addr,
                     output logic [3:0] mask, output logic web,
                     output logic gb, output int ackw);
    drive(pb, 1'b1, we, adr, dat, sel);
    tick();
    csb = bus.ram_csb0; addr = bus.ram_addr0;
    mask = bus.ram_wmask0; web = bus.ram_web0;
    gb = bus.grant_b_o;
    lat = 1;
    while (!(pb ? bus.wbsb_ack_o : bus.wbsa_ack_o) && lat < 10) begin
      tick();
      lat++;
    end
    rd = pb ? bus.wbsb_dat_o : bus.wbsa_dat_o;
    drive(pb, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    tick();
    ackw = 1 + int'(pb ? bus.wbsb_ack_o : bus.wbsa_ack_o);
  endtask

  logic [31:0] rd;
  int lat, ackw;
  logic csb, web, gb;
  logic [7:0] addr;
  logic [3:0] mask;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = i * 32'h0101_0101;
    mem[16] = 32'h0;
    bus.ram_dout0 = 32'h0;
    bus.writable_b = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

    //           pb we wrb adr            dat           sel  csb addr   rd
    v[0] = '{1'b0, 1'b0, 1'b1, 32'h10, 32'h0, 4'hF, 1'b0, 8'h04, 32'h0404_0404};
    v[1] = '{1'b0, 1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF, 4'h5, 1'b0, 8'h10, 32'h0};
    v[2] = '{1'b1, 1'b0, 1'b1, 32'h40, 32'h0, 4'hF, 1'b0, 8'h10, 32'h00AD_00EF};
    v[3] = '{1'b1, 1'b1, 1'b0, 32'h1C, 32'h1234_5678, 4'hF, 1'b1, 8'h07, 32'h0};
    v[4] = '{1'b0, 1'b0, 1'b1, 32'h1C, 32'h0, 4'hF, 1'b0, 8'h07, 32'h0707_0707};
    v[5] = '{1'b1, 1'b1, 1'b1, 32'h1C, 32'hAABB_CCDD, 4'hC, 1'b0, 8'h07, 32'h0};
    v[6] = '{1'b0, 1'b0, 1'b1, 32'h1C, 32'h0, 4'hF, 1'b0, 8'h07, 32'hAABB_0707};
    v[7] = '{1'b0, 1'b0, 1'b1, 32'hFFFF_FC10, 32'h0, 4'hF, 1'b0, 8'h04, 32'h0404_0404};
    v[8] = '{1'b1, 1'b1, 1'b1, 32'h20, 32'hFFFF_FFFF, 4'h0, 1'b0, 8'h08, 32'h0};
    v[9] = '{1'b1, 1'b0, 1'b1, 32'h20, 32'h0, 4'hF, 1'b0, 8'h08, 32'h0808_0808};

    #12;
    chk("rst_csb", bus.ram_csb0, 1'b1);
    chk("rst_web", bus.ram_web0, 1'b1);
    chk("rst_mask", bus.ram_wmask0, 4'h0);
    chk("rst_addr", bus.ram_addr0, 8'h0);
    chk("rst_din", bus.ram_din0, 32'h0);
    chk("rst_acks", {bus.wbsa_ack_o, bus.wbsb_ack_o}, 2'b00);
    chk("rst_dat_a", bus.wbsa_dat_o, 32'h0);
    chk("rst_dat_b", bus.wbsb_dat_o, 32'h0);
    chk("rst_grant", bus.grant_b_o, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("idle_csb", bus.ram_csb0, 1'b1);

    for (int i = 0; i < 10; i++) begin
      bus.writable_b = v[i].wrb;
      txn(v[i].pb, v[i].we, v[i].adr, v[i].dat, v[i].sel,
          rd, lat, csb, addr, mask, web, gb, ackw);
      chk($sformatf("v%0d_lat", i), lat, 3);
      chk($sformatf("v%0d_ackw", i), ackw, 1);
      chk($sformatf("v%0d_csb", i), csb, v[i].exp_csb);
      chk($sformatf("v%0d_addr", i), addr, v[i].exp_addr);
      chk($sformatf("v%0d_grant", i), gb, v[i].pb);
      if (v[i].we && !v[i].exp_csb) begin
        chk($sformatf("v%0d_web", i), web, 1'b0);
        chk($sformatf("v%0d_mask", i), mask, v[i].sel);
      end
      if (!v[i].we)
        chk($sformatf("v%0d_rd", i), rd, v[i].exp_rd);
    end
    bus.writable_b = 1'b1;

    // both ports request back to back: A,B,A,B,...
    begin
      int na, nb, cyc;
      bit exp_b, prev;
      na = 0; nb = 0; cyc = 0; exp_b = 1'b0; prev = 1'b0;
      drive(1'b0, 1'b1, 1'b0, 32'h04, 32'h0, 4'hF);
      drive(1'b1, 1'b1, 1'b0, 32'h08, 32'h0, 4'hF);
      while (na + nb < 8 && cyc < 100) begin
        tick();
        cyc++;
        if (bus.wbsa_ack_o || bus.wbsb_ack_o) begin
          chk("rr_overlap", bus.wbsa_ack_o & bus.wbsb_ack_o, 1'b0);
          chk("rr_pulse", prev, 1'b0);
          chk("rr_order", bus.wbsb_ack_o, exp_b);
          chk("rr_grant", bus.grant_b_o, bus.wbsb_ack_o);
          chk("rr_data",
              bus.wbsb_ack_o ? bus.wbsb_dat_o : bus.wbsa_dat_o,
              bus.wbsb_ack_o ? 32'h0202_0202 : 32'h0101_0101);
          exp_b = ~exp_b;
          if (bus.wbsb_ack_o) nb++; else na++;
          if (na == 4) drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
          if (nb == 4) drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
          prev = 1'b1;
        end else begin
          prev = 1'b0;
        end
      end
      chk("rr_count", na + nb, 8);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      tick();
      tick();
    end

    // reset during ISSUE of an A write
    drive(1'b0, 1'b1, 1'b1, 32'h50, 32'h5555_5555, 4'hF);
    tick();
    chk("rstmid_csb_pre", bus.ram_csb0, 1'b0);
    rst = 1'b1;
    #1;
    chk("rstmid_csb", bus.ram_csb0, 1'b1);
    chk("rstmid_ack", bus.wbsa_ack_o, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    tick();
    chk("rstmid_ack2", bus.wbsa_ack_o, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("rstmid_idle", bus.ram_csb0, 1'b1);
    txn(1'b0, 1'b0, 32'h50, 32'h0, 4'hF,
        rd, lat, csb, addr, mask, web, gb, ackw);
    chk("rstmid_lat", lat, 3);
    chk("rstmid_rd", rd, 32'h1414_1414);
    chk("rstmid_addr", addr, 8'h14);

    // A keeps stb through the ACK edge: no second grant
    begin
      int n;
      n = 0;
      drive(1'b0, 1'b1, 1'b0, 32'h0C, 32'h0, 4'hF);
      while (!bus.wbsa_ack_o && n < 10) begin
        tick();
        n++;
      end
      chk("hold_lat", n, 3);
      chk("hold_rd", bus.wbsa_dat_o, 32'h0303_0303);
      tick();
      chk("hold_ack_off", bus.wbsa_ack_o, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      tick();
      chk("hold_no_regrant", bus.ram_csb0, 1'b1);
      chk("hold_no_ack", bus.wbsa_ack_o, 1'b0);
      txn(1'b1, 1'b0, 32'h14, 32'h0, 4'hF,
          rd, lat, csb, addr, mask, web, gb, ackw);
      chk("hold_b_lat", lat, 3);
      chk("hold_b_grant", gb, 1'b1);
      chk("hold_b_rd", rd, 32'h0505_0505);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
